// File: rtl/obstacle_pool_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : obstacle_pkg                                              |
// | Purpose  : Shared constants and helpers for the obstacle pool        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package obstacle_pkg;

  // Default playfield geometry
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_OBS_H    = 32;

  // Exit behaviour selectors
  localparam int MODE_DESPAWN = 0;
  localparam int MODE_WRAP    = 1;

  // Largest supported pool; the allocator works on a vector of this width
  localparam int MAX_OBS = 16;

  // Lowest-index zero bit of v. Bit 4 of the result is set when every bit
  // of v is one (no free slot); bits 3:0 hold the index otherwise.
  function automatic logic [4:0] first_zero(input logic [MAX_OBS-1:0] v);
    logic [4:0] idx;
    idx = 5'b10000;
    for (int i = MAX_OBS - 1; i >= 0; i--) begin
      if (!v[i]) idx = {1'b0, 4'(i)};
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_pool_ctrl_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : obstacle_slot                                             |
// | Purpose  : One obstacle slot: x/y/active state, motion and exit      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module obstacle_slot
  import obstacle_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int OBS_H     = DEF_OBS_H,
  parameter int STEP_W    = 4,
  parameter int WRAP_MODE = MODE_DESPAWN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_en,
  input  logic               flush,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [STEP_W-1:0]  speed,
  output logic               active,
  output logic               active_next,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               exit_flag
);

  // Top row at or beyond which an obstacle counts as having left the screen
  localparam logic [COORD_W-1:0] LIMIT = COORD_W'(SCREEN_H - OBS_H);

  logic               active_q, active_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W:0]   w_sum;
  logic               w_at_limit;

  // Exit is purely positional, so a zero speed still lets a parked slot exit
  always_comb begin
    w_sum      = {1'b0, y_q} + (COORD_W + 1)'(speed);
    w_at_limit = (y_q >= LIMIT);
    exit_flag  = move_en & active_q & w_at_limit;
  end

  // Next-state: flush wins, then spawn load (only ever on an idle slot), then motion
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    if (flush) begin
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
    end else if (load) begin
      active_d = 1'b1;
      x_d      = load_x;
      y_d      = '0;
    end else if (move_en && active_q) begin
      if (w_at_limit) begin
        if (WRAP_MODE == MODE_WRAP) begin
          y_d = '0;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        y_d = COORD_W'(w_sum);
      end
    end
  end

  // Slot state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active      = active_q;
  assign active_next = active_d;
  assign x           = x_q;
  assign y           = y_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : obstacle_pool_ctrl                                        |
// | Purpose  : Pool of falling obstacles with spawn allocator and        |
// |            exit counter for scoring                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module obstacle_pool_ctrl
  import obstacle_pkg::*;
#(
  parameter int N_OBS     = 4,
  parameter int COORD_W   = 10,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int OBS_H     = DEF_OBS_H,
  parameter int STEP_W    = 4,
  parameter int CNT_W     = 16,
  parameter int WRAP_MODE = MODE_DESPAWN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     pause,
  input  logic                     clear,
  input  logic [STEP_W-1:0]        speed,
  input  logic                     spawn_req,
  input  logic [COORD_W-1:0]       spawn_x,
  output logic                     spawn_ack,
  output logic                     spawn_drop,
  output logic                     full,
  output logic [N_OBS-1:0]         obs_active,
  output logic [N_OBS*COORD_W-1:0] obs_x,
  output logic [N_OBS*COORD_W-1:0] obs_y,
  output logic                     passed_pulse,
  output logic [CNT_W-1:0]         passed_count
);

  // Elaboration-time legality checks
  if (N_OBS < 1 || N_OBS > MAX_OBS) begin : g_bad_n_obs
    $error("obstacle_pool_ctrl: N_OBS must be in 1..16");
  end
  if ((SCREEN_H - OBS_H - 1) + (2 ** STEP_W) - 1 >= (2 ** COORD_W)) begin : g_bad_range
    $error("obstacle_pool_ctrl: worst-case y overshoot does not fit in COORD_W");
  end

  logic [N_OBS-1:0]   w_active;
  logic [N_OBS-1:0]   w_active_next;
  logic [N_OBS-1:0]   w_exit;
  logic [N_OBS-1:0]   w_load;
  logic [MAX_OBS-1:0] w_pad;
  logic [4:0]         w_free;
  logic               w_found;
  logic [3:0]         w_idx;
  logic               w_move_en;
  logic               w_spawn_go;
  logic [CNT_W-1:0]   w_exit_cnt;

  logic               spawn_ack_q, spawn_ack_d;
  logic               spawn_drop_q, spawn_drop_d;
  logic               passed_pulse_q, passed_pulse_d;
  logic [CNT_W-1:0]   passed_count_q, passed_count_d;
  logic               full_q, full_d;

  // Pick the lowest free slot from pre-edge flags; unused upper bits look busy
  always_comb begin
    w_move_en  = tick & ~pause & ~clear;
    w_spawn_go = spawn_req & ~clear;
    w_pad      = '1;
    w_pad[N_OBS-1:0] = w_active;
    w_free     = first_zero(w_pad);
    w_found    = ~w_free[4];
    w_idx      = w_free[3:0];
  end

  for (genvar i = 0; i < N_OBS; i++) begin : g_slot
    assign w_load[i] = w_spawn_go & w_found & (w_idx == 4'(i));

    obstacle_slot #(
      .COORD_W   (COORD_W),
      .SCREEN_H  (SCREEN_H),
      .OBS_H     (OBS_H),
      .STEP_W    (STEP_W),
      .WRAP_MODE (WRAP_MODE)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .move_en     (w_move_en),
      .flush       (clear),
      .load        (w_load[i]),
      .load_x      (spawn_x),
      .speed       (speed),
      .active      (w_active[i]),
      .active_next (w_active_next[i]),
      .x           (obs_x[i*COORD_W +: COORD_W]),
      .y           (obs_y[i*COORD_W +: COORD_W]),
      .exit_flag   (w_exit[i])
    );
  end

  // Count every exit of this cycle so the score advances in one add
  always_comb begin
    w_exit_cnt = '0;
    for (int i = 0; i < N_OBS; i++) begin
      w_exit_cnt = w_exit_cnt + CNT_W'(w_exit[i]);
    end
  end

  // Next values of the handshake, score and full flags; clear suppresses moves and spawns upstream
  always_comb begin
    spawn_ack_d    = w_spawn_go & w_found;
    spawn_drop_d   = w_spawn_go & ~w_found;
    passed_pulse_d = |w_exit;
    passed_count_d = passed_count_q + w_exit_cnt;
    full_d         = &w_active_next;
  end

  // Status and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      spawn_ack_q    <= 1'b0;
      spawn_drop_q   <= 1'b0;
      passed_pulse_q <= 1'b0;
      passed_count_q <= '0;
      full_q         <= 1'b0;
    end else begin
      spawn_ack_q    <= spawn_ack_d;
      spawn_drop_q   <= spawn_drop_d;
      passed_pulse_q <= passed_pulse_d;
      passed_count_q <= passed_count_d;
      full_q         <= full_d;
    end
  end

  assign obs_active   = w_active;
  assign spawn_ack    = spawn_ack_q;
  assign spawn_drop   = spawn_drop_q;
  assign passed_pulse = passed_pulse_q;
  assign passed_count = passed_count_q;
  assign full         = full_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_obstacle_pool_ctrl                                     |
// | Purpose  : Directed self-checking bench; one despawn-mode and one    |
// |            wrap-mode instance share the same stimulus                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_obstacle_pool_ctrl;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int SW = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          pause = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] speed = '0;
  logic          spawn_req = 1'b0;
  logic [CW-1:0] spawn_x = '0;

  logic            d0_ack, d0_drop, d0_full, d0_pulse;
  logic [N-1:0]    d0_act;
  logic [N*CW-1:0] d0_x, d0_y;
  logic [NW-1:0]   d0_cnt;
  logic            d1_ack, d1_drop, d1_full, d1_pulse;
  logic [N-1:0]    d1_act;
  logic [N*CW-1:0] d1_x, d1_y;
  logic [NW-1:0]   d1_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obstacle_pool_ctrl #(.N_OBS(N), .COORD_W(CW), .SCREEN_H(480), .OBS_H(32),
                       .STEP_W(SW), .CNT_W(NW), .WRAP_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause), .clear(clear),
    .speed(speed), .spawn_req(spawn_req), .spawn_x(spawn_x),
    .spawn_ack(d0_ack), .spawn_drop(d0_drop), .full(d0_full),
    .obs_active(d0_act), .obs_x(d0_x), .obs_y(d0_y),
    .passed_pulse(d0_pulse), .passed_count(d0_cnt)
  );

  obstacle_pool_ctrl #(.N_OBS(N), .COORD_W(CW), .SCREEN_H(480), .OBS_H(32),
                       .STEP_W(SW), .CNT_W(NW), .WRAP_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause), .clear(clear),
    .speed(speed), .spawn_req(spawn_req), .spawn_x(spawn_x),
    .spawn_ack(d1_ack), .spawn_drop(d1_drop), .full(d1_full),
    .obs_active(d1_act), .obs_x(d1_x), .obs_y(d1_y),
    .passed_pulse(d1_pulse), .passed_count(d1_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sl(input logic [N*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  initial begin
    // Reset, then idle
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_act0", d0_act, 0);   chk("rst_act1", d1_act, 0);
    chk("rst_x0", d0_x, 0);       chk("rst_y0", d0_y, 0);
    chk("rst_flags0", {d0_ack, d0_drop, d0_full, d0_pulse}, 0);
    chk("rst_flags1", {d1_ack, d1_drop, d1_full, d1_pulse}, 0);
    chk("rst_cnt0", d0_cnt, 0);   chk("rst_cnt1", d1_cnt, 0);

    // One obstacle falls at speed 4 and leaves the screen
    spawn_req = 1'b1; spawn_x = 10'd123;
    step();
    spawn_req = 1'b0;
    chk("sp1_ack0", d0_ack, 1);   chk("sp1_act0", d0_act, 4'b0001);
    chk("sp1_x0", sl(d0_x, 0), 123);
    chk("sp1_ack1", d1_ack, 1);
    tick = 1'b1; speed = 4'd4;
    repeat (112) step();
    chk("fall_y0", sl(d0_y, 0), 448); chk("fall_y1", sl(d1_y, 0), 448);
    chk("fall_cnt0", d0_cnt, 0);      chk("fall_act1", d1_act, 4'b0001);
    step();
    chk("desp_act", d0_act, 0);       chk("desp_yhold", sl(d0_y, 0), 448);
    chk("desp_xhold", sl(d0_x, 0), 123);
    chk("desp_pulse", d0_pulse, 1);   chk("desp_cnt", d0_cnt, 1);
    chk("wrap_act", d1_act, 4'b0001); chk("wrap_y", sl(d1_y, 0), 0);
    chk("wrap_x", sl(d1_x, 0), 123);  chk("wrap_cnt", d1_cnt, 1);
    chk("wrap_pulse", d1_pulse, 1);
    tick = 1'b0;
    step();
    chk("pulse_low0", d0_pulse, 0);   chk("pulse_low1", d1_pulse, 0);

    // Clear flushes slots but keeps the score
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_act1", d1_act, 0);       chk("clr_x1", d1_x, 0);
    chk("clr_y1", d1_y, 0);           chk("clr_cnt0", d0_cnt, 1);
    chk("clr_cnt1", d1_cnt, 1);

    // Fill the pool, fifth request is dropped
    spawn_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      spawn_x = CW'((k + 1) * 100);
      step();
      if (k < 4) begin
        chk("fill_ack", d0_ack, 1);
        chk("fill_x", sl(d0_x, k), (k + 1) * 100);
        chk("fill_y", sl(d0_y, k), 0);
        chk("fill_full", d0_full, (k == 3) ? 1 : 0);
      end else begin
        chk("fill_drop", d0_drop, 1);  chk("fill_noack", d0_ack, 0);
        chk("fill_full_d1", d1_full, 1);
      end
    end
    spawn_req = 1'b0;
    chk("fill_act", d0_act, 4'b1111);
    chk("fill_xvec", d0_x, {10'd400, 10'd300, 10'd200, 10'd100});

    // Build a full pool with slot 2 about to exit while the others lag
    clear = 1'b1;
    step();
    clear = 1'b0;
    spawn_req = 1'b1; spawn_x = 10'd500;
    step(); step();
    spawn_req = 1'b0; tick = 1'b1;
    repeat (10) step();
    tick = 1'b0; spawn_req = 1'b1; spawn_x = 10'd300;
    step();
    chk("mix_act", d0_act, 4'b0111);  chk("mix_y2", sl(d0_y, 2), 0);
    spawn_req = 1'b0; tick = 1'b1;
    repeat (102) step();
    chk("mix_y0", sl(d0_y, 0), 448);  chk("mix_y2b", sl(d0_y, 2), 408);
    step();
    chk("two_exit_act", d0_act, 4'b0100); chk("two_exit_y2", sl(d0_y, 2), 412);
    chk("two_exit_cnt0", d0_cnt, 3);      chk("two_exit_cnt1", d1_cnt, 3);
    chk("two_exit_pulse", d0_pulse, 1);   chk("two_wrap_act", d1_act, 4'b0111);
    tick = 1'b0; spawn_req = 1'b1; spawn_x = 10'd600;
    repeat (3) step();
    spawn_req = 1'b0;
    chk("refill_act", d0_act, 4'b1111);   chk("refill_full", d0_full, 1);
    chk("refill_x3", sl(d0_x, 3), 600);
    tick = 1'b1;
    repeat (9) step();
    chk("pre_y2", sl(d0_y, 2), 448);      chk("pre_y3", sl(d0_y, 3), 36);
    spawn_req = 1'b1; spawn_x = 10'd700;
    step();
    chk("sim_drop", d0_drop, 1);          chk("sim_ack", d0_ack, 0);
    chk("sim_act", d0_act, 4'b1011);      chk("sim_pulse", d0_pulse, 1);
    chk("sim_cnt", d0_cnt, 4);            chk("sim_full", d0_full, 0);
    chk("sim_y0", sl(d0_y, 0), 40);
    tick = 1'b0;
    step();
    spawn_req = 1'b0;
    chk("reuse_ack", d0_ack, 1);          chk("reuse_act", d0_act, 4'b1111);
    chk("reuse_x2", sl(d0_x, 2), 700);    chk("reuse_y2", sl(d0_y, 2), 0);
    chk("reuse_full", d0_full, 1);

    // Pause freezes motion; release resumes it
    pause = 1'b1; tick = 1'b1;
    repeat (5) step();
    chk("pause_y", d0_y, {10'd40, 10'd0, 10'd40, 10'd40});
    pause = 1'b0;
    step();
    chk("resume_y", d0_y, {10'd44, 10'd4, 10'd44, 10'd44});

    // Clear overrides concurrent tick and spawn
    clear = 1'b1; spawn_req = 1'b1;
    step();
    clear = 1'b0; spawn_req = 1'b0; tick = 1'b0;
    chk("clr2_act", d0_act, 0);           chk("clr2_y", d0_y, 0);
    chk("clr2_x", d0_x, 0);               chk("clr2_cnt", d0_cnt, 4);
    chk("clr2_flags", {d0_ack, d0_drop, d0_pulse, d0_full}, 0);

    // Reset in the middle of motion
    spawn_req = 1'b1; spawn_x = 10'd55;
    step();
    spawn_req = 1'b0; tick = 1'b1;
    repeat (3) step();
    chk("mid_y0", sl(d0_y, 0), 12);
    reset = 1'b0;
    step();
    reset = 1'b1; tick = 1'b0;
    chk("mrst_act", d0_act, 0);           chk("mrst_xy", {d0_x, d0_y}, 0);
    chk("mrst_cnt0", d0_cnt, 0);          chk("mrst_cnt1", d1_cnt, 0);
    chk("mrst_flags", {d0_ack, d0_drop, d0_pulse, d0_full}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_pool_ctrl.md
Name: obstacle_pool_ctrl

Overview:
- Parametrised successor to the single-obstacle falling controller: manages a pool of N_OBS independent falling obstacles with per-slot active flags, a spawn request/ack handshake, a runtime speed, and a selectable exit mode.
- Sits between the game-logic spawner (LFSR/timer) and the HDMI sprite renderer and collision checker.
- Counts obstacles that leave the screen, for scoring.

Parameters:
- N_OBS, 4, number of obstacle slots (1..16)
- COORD_W, 10, coordinate width in bits
- SCREEN_H, 480, visible screen height in pixels
- OBS_H, 32, obstacle height in pixels
- STEP_W, 4, width of the speed input
- CNT_W, 16, width of the passed-obstacle counter
- WRAP_MODE, 0, 0 = an exiting obstacle is despawned; 1 = it re-enters at y=0 with the same x

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- tick  in  1  movement strobe, one cycle per frame
- pause  in  1  1 = ignore tick (freeze motion)
- clear  in  1  synchronous flush of all slots; counter is kept
- speed  in  STEP_W  pixels moved per tick; 0 = no motion
- spawn_req  in  1  request a new obstacle
- spawn_x  in  COORD_W  x position for the spawned obstacle
- spawn_ack  out  1  1-cycle pulse, spawn accepted
- spawn_drop  out  1  1-cycle pulse, spawn rejected (pool full)
- full  out  1  all slots active
- obs_active  out  N_OBS  per-slot active flag
- obs_x  out  N_OBS*COORD_W  flattened x; slot i is at [i*COORD_W +: COORD_W]
- obs_y  out  N_OBS*COORD_W  flattened y, same packing as obs_x
- passed_pulse  out  1  1-cycle pulse, at least one obstacle exited this cycle
- passed_count  out  CNT_W  total exits since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset==0 at a clk edge) clears every register to 0: obs_active, obs_x, obs_y, spawn_ack, spawn_drop, passed_pulse, passed_count, full.
- All outputs are registered. Effects appear one cycle after the inputs are sampled.
- Move condition for a slot: tick=1, pause=0, clear=0, and the slot is active before this edge.
  - y < SCREEN_H-OBS_H: y <= y + speed. Compute the sum in COORD_W+1 bits, then truncate. Overshoot past the limit is allowed and is handled on the next tick.
  - y >= SCREEN_H-OBS_H: the slot exits.
    - WRAP_MODE=0: active <= 0; x and y are held.
    - WRAP_MODE=1: y <= 0; x is held; the slot stays active.
- Exit accounting:
  - passed_count += popcount(exits this cycle), all exits in the cycle counted in a single add.
  - passed_pulse=1 for one cycle if any slot exits.
  - Exit detection is positional, so speed=0 does not stop exits.
- Spawn (spawn_req=1, clear=0):
  - Target is the lowest-index slot that is inactive before this edge (priority encoder).
  - If one exists: active <= 1, x <= spawn_x, y <= 0, spawn_ack=1 next cycle.
  - If none: spawn_drop=1 next cycle; no state change.
  - spawn_req held high spawns one obstacle per cycle until the pool is full.
- Tick and spawn in the same cycle:
  - The spawned slot is not moved; it starts at y=0.
  - A slot that exits in this cycle is not reusable until the next cycle, since eligibility uses pre-edge active flags.
- clear=1: all active <= 0, x/y <= 0; tick and spawn are ignored; spawn_ack=spawn_drop=passed_pulse=0; passed_count is held.
- Priority: reset > clear > (move and spawn, concurrent).
- full = AND of post-edge active flags, registered together with them.
- Parameter legality: SCREEN_H-OBS_H-1 + 2^STEP_W-1 < 2^COORD_W. Enforce with a generate-time check.

Decomposition:
- Package obstacle_pkg holds: default screen constants (SCREEN_H, OBS_H), WRAP/DESPAWN mode constants, and a first_zero priority-encoder function.
- One natural sub-module: obstacle_slot. It holds the per-slot x/y/active registers and the move/exit logic, outputs an exit flag, and is instantiated N_OBS times in a generate loop. The top holds the spawn allocator, popcount, counter and flags.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> all outputs 0, full=0, passed_count=0.
- Spawn fills pool (N_OBS=4): spawn_req held 5 cycles, spawn_x=100,200,300,400,500.
  - First 4 cycles: spawn_ack pulses; slots 0..3 get x=100..400, y=0.
  - Cycle 5: spawn_drop=1, full=1.
- Motion and despawn (WRAP_MODE=0, speed=4): one obstacle, 112 ticks.
  - y reaches 448 after 112 ticks.
  - Next tick: active=0, passed_pulse=1, passed_count=1.
- Wrap mode (WRAP_MODE=1): same stimulus as the despawn test -> y=0, x unchanged, active=1, passed_count=1.
- Simultaneous events: pool full with slot 2 at y=448; tick and spawn_req in the same cycle.
  - Slot 2 exits; spawn_drop=1.
  - Next cycle: spawn_req -> slot 2 reused with y=0.
- Pause/clear: pause=1 with ticks -> y unchanged. clear=1 -> all inactive, passed_count preserved. Reset asserted mid-motion -> all zero.
